// File: rtl/rgb_sram_uart_dump_pkg.sv
// rgb_sram_uart_dump_pkg: shared types and constants for the RGB image dump path.
//   - dump_state_e : dump FSM states (S_DUMP_HEADER exists only with PPM_HEADER_EN)
//   - image geometry and default SRAM word count
//   - PPM header ROM ("P6\n320 240\n255\n")
// Optional feature macro: PPM_HEADER_EN
package rgb_sram_uart_dump_pkg;

  localparam int unsigned IMG_WIDTH         = 320;
  localparam int unsigned IMG_HEIGHT        = 240;
  localparam int unsigned NUM_WORDS_DEFAULT = 3 * IMG_WIDTH * IMG_HEIGHT / 2;
  localparam int unsigned PPM_HDR_LEN       = 15;

  typedef enum logic [2:0] {
    S_DUMP_IDLE,
`ifdef PPM_HEADER_EN
    S_DUMP_HEADER,
`endif
    S_DUMP_READ,
    S_DUMP_WAIT,
    S_DUMP_SEND_HI,
    S_DUMP_SEND_LO,
    S_DUMP_DONE
  } dump_state_e;

  function automatic logic [7:0] ppm_header_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h50; // 'P'
      4'd1:    return 8'h36; // '6'
      4'd2:    return 8'h0A;
      4'd3:    return 8'h33; // '3'
      4'd4:    return 8'h32; // '2'
      4'd5:    return 8'h30; // '0'
      4'd6:    return 8'h20; // ' '
      4'd7:    return 8'h32; // '2'
      4'd8:    return 8'h34; // '4'
      4'd9:    return 8'h30; // '0'
      4'd10:   return 8'h0A;
      4'd11:   return 8'h32; // '2'
      4'd12:   return 8'h35; // '5'
      4'd13:   return 8'h35; // '5'
      default: return 8'h0A;
    endcase
  endfunction

endpackage

// File: rtl/rgb_sram_uart_dump_if.sv
// rgb_sram_uart_dump_if: SRAM read port shared through the top-level mux.
//   SRAM_address   [17:0] word address   (master -> slave)
//   SRAM_we_n             write enable, active-low (master -> slave)
//   SRAM_read_data [15:0] read data      (slave -> master)
interface rgb_sram_uart_dump_if;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;

  modport master (output SRAM_address, output SRAM_we_n, input SRAM_read_data);
  modport slave  (input SRAM_address, input SRAM_we_n, output SRAM_read_data);
endinterface

// File: rtl/rgb_sram_uart_dump_uart.sv
// uart_tx_byte: 8N1 UART transmitter, one byte per request.
//   clk, rst  : clock, asynchronous active-high reset
//   tx_start  : accepted when tx_busy is low; start bit appears next cycle
//   tx_data   : byte to send, LSB first
//   tx_busy   : high from the cycle after acceptance through the end of the stop bit
//   tx_o      : serial line, idle high
module uart_tx_byte #(
  parameter int unsigned CLOCKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_o
);

  localparam int unsigned CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          busy_q, busy_d;

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    if (!busy_q) begin
      if (tx_start) begin
        shift_d   = {1'b1, tx_data, 1'b0};
        busy_d    = 1'b1;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else if (clk_cnt_q == CW'(CLOCKS_PER_BIT - 1)) begin
      clk_cnt_d = '0;
      if (bit_cnt_q == 4'd9) begin
        busy_d = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {1'b1, shift_q[9:1]};
      end
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '1;
      busy_q    <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_busy = busy_q;
  // Gating by busy_q makes the line return high the instant reset hits.
  assign tx_o    = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/rgb_sram_uart_dump.sv
// rgb_sram_uart_dump: reads the decoded RGB image from SRAM and sends it over UART 8N1.
//   Clock_50       system clock
//   Reset          asynchronous active-high reset
//   Start          one-cycle dump request, accepted only when idle
//   Base_address   first SRAM word address, sampled on accepted Start
//   sram           SRAM read port (master modport); never writes
//   UART_TX_O      serial output, idle high
//   Busy           high from accepted Start until Done
//   Done           one-cycle pulse the cycle after the final stop bit
// Optional feature macro: PPM_HEADER_EN (prepends a 15-byte PPM header)
module rgb_sram_uart_dump
  import rgb_sram_uart_dump_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 434,
  parameter int unsigned NUM_WORDS      = NUM_WORDS_DEFAULT,
  parameter int unsigned READ_LATENCY   = 2
) (
  input  logic                        Clock_50,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [17:0]                 Base_address,
  rgb_sram_uart_dump_if.master        sram,
  output logic                        UART_TX_O,
  output logic                        Busy,
  output logic                        Done
);

  dump_state_e state_q, state_d;
  logic [17:0] base_q, base_d;
  logic [16:0] cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  wait_q, wait_d;
  logic        busy_q, busy_d;
`ifdef PPM_HEADER_EN
  logic [3:0]  hdr_idx_q, hdr_idx_d;
`endif

  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    word_d   = word_q;
    wait_d   = wait_q;
    busy_d   = busy_q;
    tx_start = 1'b0;
    tx_data  = word_q[15:8];
    Done     = 1'b0;
`ifdef PPM_HEADER_EN
    hdr_idx_d = hdr_idx_q;
`endif
    unique case (state_q)
      S_DUMP_IDLE: begin
        if (Start) begin
          base_d = Base_address;
          cnt_d  = '0;
          busy_d = 1'b1;
`ifdef PPM_HEADER_EN
          hdr_idx_d = '0;
          state_d   = S_DUMP_HEADER;
`else
          state_d   = S_DUMP_READ;
`endif
        end
      end
`ifdef PPM_HEADER_EN
      S_DUMP_HEADER: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = ppm_header_byte(hdr_idx_q);
          if (hdr_idx_q == 4'(PPM_HDR_LEN - 1)) state_d = S_DUMP_READ;
          else hdr_idx_d = hdr_idx_q + 4'd1;
        end
      end
`endif
      S_DUMP_READ: begin
        addr_d  = base_q + 18'(cnt_q);
        wait_d  = '0;
        state_d = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (wait_q == 8'(READ_LATENCY)) begin
          word_d  = sram.SRAM_read_data;
          state_d = S_DUMP_SEND_HI;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DUMP_SEND_HI: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = word_q[15:8];
          state_d  = S_DUMP_SEND_LO;
        end
      end
      S_DUMP_SEND_LO: begin
        // The next word is fetched while this low byte is still shifting out.
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = word_q[7:0];
          cnt_d    = cnt_q + 17'd1;
          state_d  = (cnt_q + 17'd1 == 17'(NUM_WORDS)) ? S_DUMP_DONE : S_DUMP_READ;
        end
      end
      S_DUMP_DONE: begin
        if (!tx_busy) begin
          Done    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DUMP_IDLE;
        end
      end
      default: state_d = S_DUMP_IDLE;
    endcase
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= S_DUMP_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
`ifdef PPM_HEADER_EN
      hdr_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
`ifdef PPM_HEADER_EN
      hdr_idx_q <= hdr_idx_d;
`endif
    end
  end

  assign sram.SRAM_address = addr_q;
  assign sram.SRAM_we_n    = 1'b1;
  assign Busy              = busy_q;

  uart_tx_byte #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_tx (
    .clk      (Clock_50),
    .rst      (Reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_o     (UART_TX_O)
  );

endmodule

// File: tb/tb_rgb_sram_uart_dump.sv
// Testbench for rgb_sram_uart_dump: SRAM model with 2-cycle read latency, UART
// line decoder with per-cycle bit timing checks, and an expected-byte queue.
// Honours PPM_HEADER_EN (header expected, NUM_WORDS=1).
module tb_rgb_sram_uart_dump;

  localparam int unsigned CPB = 4;
`ifdef PPM_HEADER_EN
  localparam int unsigned NW  = 1;
  localparam int          NFR = 15 + 2 * NW;
`else
  localparam int unsigned NW  = 2;
  localparam int          NFR = 2 * NW;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] base;
  logic        tx, busy, done;

  rgb_sram_uart_dump_if sram_bus ();

  rgb_sram_uart_dump #(
    .CLOCKS_PER_BIT (CPB),
    .NUM_WORDS      (NW),
    .READ_LATENCY   (2)
  ) dut (
    .Clock_50     (clk),
    .Reset        (rst),
    .Start        (start),
    .Base_address (base),
    .sram         (sram_bus),
    .UART_TX_O    (tx),
    .Busy         (busy),
    .Done         (done)
  );

  always #5 clk = ~clk;

  // SRAM model: data for the address seen at cycle n is valid at cycle n+2.
  bit [15:0]   mem [0:262143];
  logic [15:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    rd_p1 <= mem[sram_bus.SRAM_address];
    rd_p2 <= rd_p1;
  end
  assign sram_bus.SRAM_read_data = rd_p2;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  string      hdr = "P6\n320 240\n255\n";

  // Line monitor / decoder
  int         cyc = 0;
  int         rx_pos = -1;
  logic [9:0] rx_bits;
  logic       rx_bad;
  int         gap = 0;
  int         frames_rx = 0;
  int         frames_in_dump = 0;
  int         last_stop_cyc = -10;
  int         done_cnt = 0;
  int         we_bad = 0;

  always @(negedge clk) begin
    int bi;
    cyc++;
    if (sram_bus.SRAM_we_n !== 1'b1) we_bad++;
    if (done === 1'b1) begin
      done_cnt++;
      check("done_timing", cyc, last_stop_cyc + 1);
    end
    if (rst) begin
      rx_pos = -1;
    end else if (rx_pos < 0) begin
      if (tx === 1'b0) begin
        if (frames_in_dump > 0) check("frame_gap_le2", (gap <= 2) ? 1 : 0, 1);
        rx_bits    = '1;
        rx_bits[0] = 1'b0;
        rx_bad     = 1'b0;
        rx_pos     = 1;
      end else begin
        gap++;
      end
    end else begin
      bi = rx_pos / CPB;
      if (rx_pos % CPB == 0) rx_bits[bi] = tx;
      else if (tx !== rx_bits[bi]) rx_bad = 1'b1;
      rx_pos++;
      if (rx_pos == 10 * CPB) begin
        check("frame_shape", rx_bad, 0);
        check("stop_bit", rx_bits[9], 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %0h expected no frame", rx_bits[8:1]);
        end else begin
          check("rx_byte", rx_bits[8:1], exp_q.pop_front());
        end
        frames_rx++;
        frames_in_dump++;
        gap           = 0;
        last_stop_cyc = cyc;
        rx_pos        = -1;
      end
    end
  end

  typedef struct {
    logic [17:0] base;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [31:0] exp_bytes; // first byte in [31:24]
  } vec_t;
  vec_t vecs [3];

  task automatic load_vec(input int v);
    logic [17:0] a;
    a      = vecs[v].base;
    mem[a] = vecs[v].w0;
    a      = a + 18'd1;
    mem[a] = vecs[v].w1;
  endtask

  task automatic push_expected(input int v);
`ifdef PPM_HEADER_EN
    for (int i = 0; i < 15; i++) exp_q.push_back(hdr[i]);
`endif
    for (int i = 0; i < 2 * int'(NW); i++) exp_q.push_back(vecs[v].exp_bytes[31 - 8*i -: 8]);
  endtask

  task automatic pulse_start(input logic [17:0] b, input bit new_dump);
    @(negedge clk); #1;
    start = 1'b1;
    base  = b;
    if (new_dump) frames_in_dump = 0;
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == d0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no Done expected Done within 2000 cycles");
    end
  endtask

  task automatic run_vec(input int v);
    int f0, d0;
    push_expected(v);
    f0 = frames_rx;
    d0 = done_cnt;
    pulse_start(vecs[v].base, 1'b1);
    wait_done(d0);
    check("frame_count", frames_rx - f0, NFR);
    check("queue_empty", exp_q.size(), 0);
    @(negedge clk); #1;
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int f0, d0, n;
    vecs[0] = '{base: 18'h23E00, w0: 16'hA55A, w1: 16'h1234, exp_bytes: 32'hA55A1234};
    vecs[1] = '{base: 18'h3FFFF, w0: 16'hBEEF, w1: 16'hC0DE, exp_bytes: 32'hBEEFC0DE};
    vecs[2] = '{base: 18'h00100, w0: 16'h0100, w1: 16'hFF80, exp_bytes: 32'h0100FF80};

    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_addr", sram_bus.SRAM_address, 0);
    check("rst_we_n", sram_bus.SRAM_we_n, 1);
    check("rst_tx",   tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Table: basic dump, address wrap, bit-pattern timing (0x01/0x00/0xFF)
    for (int v = 0; v < 3; v++) begin
      load_vec(v);
      run_vec(v);
    end

    // Start re-pulsed mid-dump is ignored
    load_vec(0);
    push_expected(0);
    f0 = frames_rx;
    d0 = done_cnt;
    pulse_start(vecs[0].base, 1'b1);
    repeat (30) @(negedge clk);
    pulse_start(vecs[1].base, 1'b0);
    wait_done(d0);
    repeat (150) @(negedge clk);
    #1;
    check("restart_done_pulses", done_cnt - d0, 1);
    check("restart_frames", frames_rx - f0, NFR);
    check("restart_queue_empty", exp_q.size(), 0);
    check("restart_busy_idle", busy, 0);

    // Reset during the data bits of the second frame, then restart
    push_expected(0);
    f0 = frames_rx;
    pulse_start(vecs[0].base, 1'b1);
    n = 0;
    while (!(frames_rx == f0 + 1 && rx_pos > int'(CPB)) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check("reset_point_reached", (frames_rx == f0 + 1 && rx_pos > int'(CPB)) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    check("midrst_tx",   tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    run_vec(0);

    check("we_n_never_low", we_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected completion before 1000000");
    $fatal(1, "watchdog");
  end

endmodule
